fetch_queue: RTL and testbench
==============================

# fetch_queue

- Instruction queue between `fetch` and `decode`.
- Decouples the fetch stream from scoreboard stalls, so fetch keeps running while decode is held.
- Buffers up to DEPTH fetched instructions with their PCs in program order.
- Presents the oldest entry at DE0 using the existing `fe_valid_de0` / `instr_de0` / `stall` contract.
- A flush input empties the queue on redirects.

## Interface
Parameters:
- DEPTH, default 4: number of entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  core clock. One clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_fe1  in  1  fetch presents an instruction this cycle.
- instr_fe1  in  t_rv_instr (32)  instruction word from fetch.
- pc_fe1  in  t_rv_pc (32)  PC of instr_fe1.
- ready_fe1  out  1  queue can accept this cycle; registered-state only, no path from stall.
- flush  in  1  discard all entries (redirect).
- stall  in  1  scoreboard stall; the DE0 head must hold.
- fe_valid_de0  out  1  head entry valid at DE0.
- instr_de0  out  t_rv_instr  head instruction; '0 when fe_valid_de0=0.
- pc_de0  out  t_rv_pc  head PC; '0 when fe_valid_de0=0.
- count  out  $clog2(DEPTH+1)  current occupancy, for debug and assertions.

## Operation
- Enqueue (enq) = valid_fe1 & ready_fe1 & !flush.
  - Writes {pc_fe1, instr_fe1} at the write pointer; the write pointer increments.
- valid_fe1 while ready_fe1=0 is a protocol error (assertion).
  - The entry is dropped; state is unchanged.
- Dequeue (deq) = fe_valid_de0 & !stall & !flush.
  - The read pointer increments.
- fe_valid_de0 = (count != 0).
- Head outputs come from the flop array at the read pointer.
- ready_fe1 = !reset & (count < DEPTH).
  - When full, no enqueue is possible even if a dequeue happens the same cycle; this is deliberate to avoid a stall-to-fetch timing path.
- count_next = count + enq - deq. Simultaneous enq and deq leave count unchanged and advance both pointers.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Flush has priority over everything. Next cycle:
  - count=0 and both pointers=0;
  - the enqueue and dequeue of the flush cycle are both discarded.
- While stall=1, the head entry (instr_de0, pc_de0, fe_valid_de0) is held stable; enqueues continue if not full.
- Reset has priority over flush. Reset mid-operation empties the queue exactly as flush does.
- Reset values: count=0, fe_valid_de0=0, instr_de0='0, pc_de0='0, ready_fe1=0.
  - ready_fe1 goes to 1 in the first cycle with reset=0.
- Storage contents are not reset. Outputs are zero-gated when the queue is empty.

## Timing
- Latency: an entry enqueued in cycle N is visible at DE0 in cycle N+1 at the earliest. There is no same-cycle bypass.
- Throughput: one enqueue and one dequeue per cycle in steady state.
- ready_fe1 in cycle N reflects the count registered at the end of N-1.
- The flush in cycle N is visible in cycle N+1: fe_valid_de0=0 and ready_fe1=1.
- A new enqueue is accepted in cycle N+1 and appears at DE0 in N+2.

## Structure
- Add `t_rv_pc` (32-bit) to the shared `instr` package.
- Add the packed `t_fq_entry` {t_rv_pc pc; t_rv_instr instr;} to the same package.
- Add `FQ_DEPTH` (default 4) to the core configuration constants; the core instantiates fetch_queue with it.
- No sub-module: the flop array, pointers and count live inline.
- Assertions under `ASSERT`:
  - no enq when full;
  - count <= DEPTH;
  - head stable while stall & fe_valid_de0.
- Integration: fetch's current `fe_valid_de0` / `instr_de0` outputs are renamed to `valid_fe1` / `instr_fe1`, and fetch gains `pc_fe1` and `ready_fe1` ports.

## Test plan
- Reset, then stream 0x00000013 at PCs 0x0,0x4,0x8 with stall=0.
  - Each appears at DE0 one cycle after enqueue; count never exceeds 1.
- Hold stall=1 and present 6 instructions back-to-back.
  - Accepts 4; ready_fe1=0 from the cycle after the 4th; instr_de0 holds the first entry.
  - Release stall: the entries drain in order, PCs 0x0..0xC.
- With count=4 and stall=0, assert valid_fe1.
  - ready_fe1=0 that cycle; the entry is not accepted.
  - Next cycle count=3 and ready_fe1=1.
- Steady state at count=2 with enq and deq every cycle for 10 cycles.
  - count stays 2; pointers wrap past 3→0 with correct order.
- flush with count=3 and valid_fe1=1.
  - Next cycle fe_valid_de0=0, count=0, the flush-cycle entry is absent, instr_de0='0.
  - A subsequent enqueue at PC 0x100 appears at DE0 in cycle N+2.
- Assert reset mid-stream with count=2.
  - Next cycle count=0, ready_fe1=0 while reset is held, 1 in the first cycle after release.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared instruction types and core configuration constants used by the
// fetch queue sitting between fetch and decode.
package fetch_queue_pkg;

    localparam int FQ_DEPTH = 4;

    typedef logic [31:0] t_rv_instr;
    typedef logic [31:0] t_rv_pc;

    typedef struct packed {
        t_rv_pc    pc;
        t_rv_instr instr;
    } t_fq_entry;

endpackage

// File: rtl/fetch_queue_chk.sv
// Property checker for fetch_queue: occupancy bounds and head stability
// while decode is stalled. Only present in builds that define ASSERT.
`ifdef ASSERT
module fetch_queue_chk
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input logic             clk,
    input logic             reset,
    input logic             flush,
    input logic             stall,
    input logic             enq,
    input logic             fe_valid_de0,
    input logic [CNT_W-1:0] count,
    input t_rv_instr        instr_de0,
    input t_rv_pc           pc_de0
);

    a_no_enq_full: assert property (@(posedge clk) disable iff (reset)
        enq |-> (count < CNT_W'(DEPTH)));

    a_count_max: assert property (@(posedge clk) disable iff (reset)
        count <= CNT_W'(DEPTH));

    // A flush may legitimately replace the head even while stalled.
    a_head_stable: assert property (@(posedge clk) disable iff (reset)
        (stall && fe_valid_de0 && !flush) |=>
            (fe_valid_de0 && $stable(instr_de0) && $stable(pc_de0)));

endmodule
`endif

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: buffers up to DEPTH
// {pc, instr} pairs in program order and presents the oldest at DE0.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_fe1,
    input  t_rv_instr                  instr_fe1,
    input  t_rv_pc                     pc_fe1,
    output logic                       ready_fe1,
    input  logic                       flush,
    input  logic                       stall,
    output logic                       fe_valid_de0,
    output t_rv_instr                  instr_de0,
    output t_rv_pc                     pc_de0,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of 2 and at least 2");
    end

    t_fq_entry        mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic      full_s;
    logic      empty_s;
    logic      enq_s;
    logic      deq_s;
    t_fq_entry head_s;

    // ready depends only on registered occupancy, never on stall, so a
    // full queue refuses fetch even if decode drains in the same cycle.
    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty_s   = (count_r == CNT_W'(0));
    assign ready_fe1 = !reset && !full_s;
    assign enq_s     = valid_fe1 && ready_fe1 && !flush;
    assign deq_s     = !empty_s && !stall && !flush;

    // Pointer and occupancy update; reset outranks flush, flush outranks traffic.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_r[wr_ptr_r] <= '{pc: pc_fe1, instr: instr_fe1};
        end
    end

    // Head selection, zero-gated when the queue is empty.
    always_comb begin
        head_s = '0;
        if (!empty_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign fe_valid_de0 = !empty_s;
    assign instr_de0    = head_s.instr;
    assign pc_de0       = head_s.pc;
    assign count        = count_r;

`ifdef ASSERT
    fetch_queue_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .stall        (stall),
        .enq          (enq_s),
        .fe_valid_de0 (fe_valid_de0),
        .count        (count_r),
        .instr_de0    (instr_de0),
        .pc_de0       (pc_de0)
    );
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4): streaming, stall
// fill and drain, full refusal, steady-state wrap, flush and reset.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic      clk;
    logic      reset;
    logic      valid_fe1;
    t_rv_instr instr_fe1;
    t_rv_pc    pc_fe1;
    logic      ready_fe1;
    logic      flush;
    logic      stall;
    logic      fe_valid_de0;
    t_rv_instr instr_de0;
    t_rv_pc    pc_de0;
    logic [2:0] count;

    int n_checks;
    int n_errors;

    fetch_queue #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_fe1    (valid_fe1),
        .instr_fe1    (instr_fe1),
        .pc_fe1       (pc_fe1),
        .ready_fe1    (ready_fe1),
        .flush        (flush),
        .stall        (stall),
        .fe_valid_de0 (fe_valid_de0),
        .instr_de0    (instr_de0),
        .pc_de0       (pc_de0),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic fl, input logic rst);
        valid_fe1 = v;
        instr_fe1 = ins;
        pc_fe1    = pc;
        stall     = st;
        flush     = fl;
        reset     = rst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(fe_valid_de0), 32'd0);
        check("rst_instr", instr_de0, 32'h0);
        check("rst_pc", pc_de0, 32'h0);
        check("rst_ready", 32'(ready_fe1), 32'd0);

        // First cycle out of reset: ready rises, nothing at DE0 yet
        drive(1'b1, 32'h00000013, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rel_ready", 32'(ready_fe1), 32'd1);
        check("s1_lat0", 32'(fe_valid_de0), 32'd0);
        tick();
        for (int i = 1; i < 4; i++) begin
            if (i < 3) drive(1'b1, 32'h00000013, 32'(4 * i), 1'b0, 1'b0, 1'b0);
            else       drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            check("s1_valid", 32'(fe_valid_de0), 32'd1);
            check("s1_pc", pc_de0, 32'(4 * (i - 1)));
            check("s1_instr", instr_de0, 32'h00000013);
            check("s1_count", 32'(count), 32'd1);
            tick();
        end
        check("s1_empty", 32'(fe_valid_de0), 32'd0);

        // Stall and present 6 back-to-back; only 4 fit
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 32'(4 * i), 1'b1, 1'b0, 1'b0);
            check("s2_ready", 32'(ready_fe1), (i < 4) ? 32'd1 : 32'd0);
            if (i > 0) begin
                check("s2_hold_instr", instr_de0, 32'h100);
                check("s2_hold_pc", pc_de0, 32'h0);
            end
            tick();
        end
        // Full with stall released and valid asserted: refused, head drains
        drive(1'b1, 32'h1FF, 32'h40, 1'b0, 1'b0, 1'b0);
        check("s3_count_full", 32'(count), 32'd4);
        check("s3_ready_full", 32'(ready_fe1), 32'd0);
        check("s3_pc0", pc_de0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("s3_count_after", 32'(count), 32'd3);
        check("s3_ready_after", 32'(ready_fe1), 32'd1);
        for (int k = 1; k < 4; k++) begin
            check("s3_drain_pc", pc_de0, 32'(4 * k));
            check("s3_drain_instr", instr_de0, 32'h100 + 32'(k));
            tick();
        end
        check("s3_empty", 32'(count), 32'd0);

        // Steady state at count=2, pointers wrap several times
        drive(1'b1, 32'hA00, 32'h200, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hA01, 32'h204, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'hA02 + 32'(k), 32'h208 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
            check("s4_count", 32'(count), 32'd2);
            check("s4_pc", pc_de0, 32'h200 + 32'(4 * k));
            check("s4_instr", instr_de0, 32'hA00 + 32'(k));
            tick();
        end

        // Grow to 3, then flush with a valid fetch in the same cycle
        drive(1'b1, 32'hA0C, 32'h230, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hBAD, 32'h300, 1'b0, 1'b1, 1'b0);
        check("s5_count_pre", 32'(count), 32'd3);
        check("s5_pc_pre", pc_de0, 32'h228);
        tick();
        drive(1'b1, 32'hABC, 32'h100, 1'b0, 1'b0, 1'b0);
        check("s5_valid", 32'(fe_valid_de0), 32'd0);
        check("s5_count", 32'(count), 32'd0);
        check("s5_instr", instr_de0, 32'h0);
        check("s5_pc", pc_de0, 32'h0);
        check("s5_ready", 32'(ready_fe1), 32'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("s5_new_valid", 32'(fe_valid_de0), 32'd1);
        check("s5_new_pc", pc_de0, 32'h100);
        check("s5_new_instr", instr_de0, 32'hABC);
        tick();
        check("s5_drained", 32'(count), 32'd0);

        // Reset mid-stream with two entries queued
        drive(1'b1, 32'hC00, 32'h500, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hC01, 32'h504, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("s6_count_pre", 32'(count), 32'd2);
        check("s6_ready_in_rst", 32'(ready_fe1), 32'd0);
        tick();
        check("s6_count_rst", 32'(count), 32'd0);
        check("s6_valid_rst", 32'(fe_valid_de0), 32'd0);
        check("s6_ready_held", 32'(ready_fe1), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("s6_ready_rel", 32'(ready_fe1), 32'd1);
        check("s6_count_rel", 32'(count), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
